// File: rtl/fpu_pkg.sv
// Shared floating-point helpers: operand classes, exponent bias and the canonical quiet NaN.
package fpu_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Widest word the qNaN helper can build; callers slice the low W bits.
  localparam int unsigned FP_MAX_W = 128;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
    logic [FP_MAX_W-1:0] one;
    logic [FP_MAX_W-1:0] r;
    one = FP_MAX_W'(1);
    r   = (((one << exp_w) - one) << man_w) | (one << (man_w - 32'd1));
    return r;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational back end of the multiplier: normalise, round, resolve special
// operands and pack the result word with its status flags.
module fmul_round
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned RND_RNE = 1
) (
  input  logic                   sign,
  input  logic [1:0]             cls_a,
  input  logic [1:0]             cls_b,
  input  logic [2*MAN_W+1:0]     prod,
  input  logic [EXP_W+1:0]       exp_sum,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   udf,
  output logic                   nv
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned XW = EXP_W + 2;
  localparam logic [FP_MAX_W-1:0] QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic signed [XW-1:0] E_MAX = XW'((1 << EXP_W) - 1);

  logic [PW-2:0]          norm;
  logic [MAN_W-1:0]       mant;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic [MAN_W:0]         mant_r;
  logic signed [XW-1:0]   e_n;
  logic signed [XW-1:0]   e_r;
  logic                   any_nan;
  logic                   any_inf;
  logic                   any_zero;
  logic                   inf_times_zero;

  always_comb begin
    // Drop the leading one; a clear MSB means the product sits one bit lower.
    norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    mant   = norm[PW-2:MAN_W+1];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    e_n    = $signed(exp_sum) + $signed({{(XW-1){1'b0}}, prod[PW-1]});

    inc    = (RND_RNE != 0) && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    e_r    = e_n + $signed({{(XW-1){1'b0}}, mant_r[MAN_W]});

    any_nan        = (cls_a == CLS_NAN)  || (cls_b == CLS_NAN);
    any_inf        = (cls_a == CLS_INF)  || (cls_b == CLS_INF);
    any_zero       = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
    inf_times_zero = any_inf && any_zero;

    y   = {sign, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
    ovf = 1'b0;
    udf = 1'b0;
    nv  = 1'b0;

    if (any_nan || inf_times_zero) begin
      y  = QNAN_WIDE[W-1:0];
      nv = 1'b1;
    end else if (any_inf) begin
      y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      y = {sign, {(W-1){1'b0}}};
    end else if (e_n[XW-1] || (e_n == '0)) begin
      y   = {sign, {(W-1){1'b0}}};
      udf = 1'b1;
    end else if (e_r >= E_MAX) begin
      y   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with a global advance signal:
// S1 unpack/classify, S2 significand multiply and exponent sum, S3 round and pack.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned RND_RNE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x1,
  input  logic [EXP_W+MAN_W:0] x2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 ovf,
  output logic                 udf,
  output logic                 nv
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == '0)      return CLS_ZERO;
    else if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    else              return CLS_NORM;
  endfunction

  logic adv;

  logic                 v1_q, v1_d;
  logic                 s1_sign_q, s1_sign_d;
  fp_class_e            s1_cls_a_q, s1_cls_a_d;
  fp_class_e            s1_cls_b_q, s1_cls_b_d;
  logic [EXP_W-1:0]     s1_exp_a_q, s1_exp_a_d;
  logic [EXP_W-1:0]     s1_exp_b_q, s1_exp_b_d;
  logic [MAN_W:0]       s1_sig_a_q, s1_sig_a_d;
  logic [MAN_W:0]       s1_sig_b_q, s1_sig_b_d;

  logic                 v2_q, v2_d;
  logic                 s2_sign_q, s2_sign_d;
  fp_class_e            s2_cls_a_q, s2_cls_a_d;
  fp_class_e            s2_cls_b_q, s2_cls_b_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;
  logic signed [XW-1:0] s2_exp_q, s2_exp_d;

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         y_q, y_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 nv_q, nv_d;

  logic [W-1:0]         r_y;
  logic                 r_ovf;
  logic                 r_udf;
  logic                 r_nv;

  fmul_round #(
    .EXP_W   (EXP_W),
    .MAN_W   (MAN_W),
    .RND_RNE (RND_RNE)
  ) u_round (
    .sign    (s2_sign_q),
    .cls_a   (s2_cls_a_q),
    .cls_b   (s2_cls_b_q),
    .prod    (s2_prod_q),
    .exp_sum (s2_exp_q),
    .y       (r_y),
    .ovf     (r_ovf),
    .udf     (r_udf),
    .nv      (r_nv)
  );

  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = adv;

    v1_d        = v1_q;
    s1_sign_d   = s1_sign_q;
    s1_cls_a_d  = s1_cls_a_q;
    s1_cls_b_d  = s1_cls_b_q;
    s1_exp_a_d  = s1_exp_a_q;
    s1_exp_b_d  = s1_exp_b_q;
    s1_sig_a_d  = s1_sig_a_q;
    s1_sig_b_d  = s1_sig_b_q;
    v2_d        = v2_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_a_d  = s2_cls_a_q;
    s2_cls_b_d  = s2_cls_b_q;
    s2_prod_d   = s2_prod_q;
    s2_exp_d    = s2_exp_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    nv_d        = nv_q;

    // Valid bits always shift on advance so bubbles travel; payloads load only with data.
    if (adv) begin
      v1_d        = in_valid;
      v2_d        = v1_q;
      out_valid_d = v2_q;

      if (in_valid) begin
        s1_sign_d  = x1[W-1] ^ x2[W-1];
        s1_cls_a_d = classify(x1[W-2:MAN_W], x1[MAN_W-1:0]);
        s1_cls_b_d = classify(x2[W-2:MAN_W], x2[MAN_W-1:0]);
        s1_exp_a_d = x1[W-2:MAN_W];
        s1_exp_b_d = x2[W-2:MAN_W];
        s1_sig_a_d = {1'b1, x1[MAN_W-1:0]};
        s1_sig_b_d = {1'b1, x2[MAN_W-1:0]};
      end

      if (v1_q) begin
        s2_sign_d  = s1_sign_q;
        s2_cls_a_d = s1_cls_a_q;
        s2_cls_b_d = s1_cls_b_q;
        s2_prod_d  = PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
        s2_exp_d   = $signed({2'b00, s1_exp_a_q}) + $signed({2'b00, s1_exp_b_q}) - BIAS_X;
      end

      if (v2_q) begin
        y_d   = r_y;
        ovf_d = r_ovf;
        udf_d = r_udf;
        nv_d  = r_nv;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q        <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_a_q  <= CLS_ZERO;
      s1_cls_b_q  <= CLS_ZERO;
      s1_exp_a_q  <= '0;
      s1_exp_b_q  <= '0;
      s1_sig_a_q  <= '0;
      s1_sig_b_q  <= '0;
      v2_q        <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_a_q  <= CLS_ZERO;
      s2_cls_b_q  <= CLS_ZERO;
      s2_prod_q   <= '0;
      s2_exp_q    <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      nv_q        <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      s1_exp_a_q  <= s1_exp_a_d;
      s1_exp_b_q  <= s1_exp_b_d;
      s1_sig_a_q  <= s1_sig_a_d;
      s1_sig_b_q  <= s1_sig_b_d;
      v2_q        <= v2_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_a_q  <= s2_cls_a_d;
      s2_cls_b_q  <= s2_cls_b_d;
      s2_prod_q   <= s2_prod_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      nv_q        <= nv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign nv        = nv_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: a round-to-nearest-even instance and a truncating
// instance share stimulus; every expected value below is hand-computed.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x1, x2;

  logic        in_ready, out_valid, ovf, udf, nv;
  logic [31:0] y;
  logic        in_ready_t, out_valid_t, ovf_t, udf_t, nv_t;
  logic [31:0] y_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .RND_RNE(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .udf(udf), .nv(nv)
  );

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .RND_RNE(0)) dut_tr (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
    .x1(x1), .x2(x2), .out_valid(out_valid_t), .out_ready(out_ready),
    .y(y_t), .ovf(ovf_t), .udf(udf_t), .nv(nv_t)
  );

  // Drives one operand pair into an empty pipeline and waits for its result;
  // lat counts rising edges from the accepting edge (inclusive) to out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ry, output logic [31:0] ryt,
                       output logic [2:0] rf, output logic [2:0] rft,
                       output int lat);
    lat = 0;
    @(negedge clk);
    x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
    end
    ry  = y;
    ryt = y_t;
    rf  = {ovf, udf, nv};
    rft = {ovf_t, udf_t, nv_t};
  endtask

  task automatic test_reset;
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1 = '0; x2 = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_valid_t !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b, required 0/0", out_valid, out_valid_t);
    end
    n_tests++;
    if (y !== 32'h0 || {ovf, udf, nv} !== 3'b000) begin
      n_fail++; $display("FAIL reset_out: y=%h flags=%b, required 00000000/000", y, {ovf, udf, nv});
    end
    n_tests++;
    if (in_ready !== 1'b1 || in_ready_t !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b, required 1/1", in_ready, in_ready_t);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] va[3], vb[3], ve[3];
    logic [31:0] ry, ryt;
    logic [2:0]  rf, rft;
    int lat;
    va = '{32'h40000000, 32'hC0000000, 32'h3F800000};
    vb = '{32'h40400000, 32'h40400000, 32'h3F800000};
    ve = '{32'h40C00000, 32'hC0C00000, 32'h3F800000};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], ry, ryt, rf, rft, lat);
      n_tests++;
      if (ry !== ve[i] || rf !== 3'b000) begin
        n_fail++; $display("FAIL basic_%0d: y=%h flags=%b, required %h/000", i, ry, rf, ve[i]);
      end
      n_tests++;
      if (lat != 3) begin
        n_fail++; $display("FAIL basic_latency_%0d: got %0d edges, required 3", i, lat);
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] ry, ryt;
    logic [2:0]  rf, rft;
    int lat;
    // 1.5*(1+2^-23): an exact tie between mantissas ...001 and ...002.
    issue(32'h3F800001, 32'h3FC00000, ry, ryt, rf, rft, lat);
    n_tests++;
    if (ry !== 32'h3FC00002) begin
      n_fail++; $display("FAIL tie_rne: y=%h, required 3FC00002", ry);
    end
    n_tests++;
    if (ryt !== 32'h3FC00001 || rft !== 3'b000) begin
      n_fail++; $display("FAIL tie_trunc: y=%h flags=%b, required 3FC00001/000", ryt, rft);
    end
    // (1+2^-23)*(2-2^-22) = 2-2^-45: rounding carries out of the mantissa.
    issue(32'h3F800001, 32'h3FFFFFFE, ry, ryt, rf, rft, lat);
    n_tests++;
    if (ry !== 32'h40000000 || rf !== 3'b000) begin
      n_fail++; $display("FAIL carry_rne: y=%h flags=%b, required 40000000/000", ry, rf);
    end
    n_tests++;
    if (ryt !== 32'h3FFFFFFF) begin
      n_fail++; $display("FAIL carry_trunc: y=%h, required 3FFFFFFF", ryt);
    end
  endtask

  task automatic test_specials;
    logic [31:0] va[7], vb[7], ve[7];
    logic [2:0]  vf[7];
    logic [31:0] ry, ryt;
    logic [2:0]  rf, rft;
    int lat;
    va = '{32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000,
           32'h7FC12345, 32'h7F800000, 32'h00000001};
    vb = '{32'h40000000, 32'h3F000000, 32'h3F800000, 32'h00000000,
           32'h3F800000, 32'hC0000000, 32'h40000000};
    ve = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h7FC00000,
           32'h7FC00000, 32'hFF800000, 32'h00000000};
    vf = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], ry, ryt, rf, rft, lat);
      n_tests++;
      if (ry !== ve[i] || rf !== vf[i]) begin
        n_fail++;
        $display("FAIL special_%0d: y=%h ovf/udf/nv=%b, required %h/%b", i, ry, rf, ve[i], vf[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] va[6], ve[6];
    int idx = 0;
    int got = 0;
    va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    ve = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      if (idx < 6) begin
        in_valid = 1'b1; x1 = va[idx]; x2 = 32'h40000000;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 4 && cyc < 8) begin
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== ve[0] || idx != 3) begin
          n_fail++;
          $display("FAIL stall_c%0d: out_valid=%b in_ready=%b y=%h accepted=%0d, required 1/0/%h/3",
                   cyc, out_valid, in_ready, y, idx, ve[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (got >= 6) begin
          n_fail++; $display("FAIL bp_extra: result %0d y=%h, required no more than 6", got, y);
        end else if (y !== ve[got]) begin
          n_fail++; $display("FAIL bp_order_%0d: y=%h, required %h", got, y, ve[got]);
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 6) begin
      n_fail++; $display("FAIL bp_count: got %0d results, required 6", got);
    end
  endtask

  task automatic test_bubbles;
    logic pv[24];
    logic exp_v;
    for (int c = 0; c < 24; c++) pv[c] = (c < 10) ? (c % 2 == 0) : (c < 18);
    out_ready = 1'b1; x1 = 32'h3F800000; x2 = 32'h40000000;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      exp_v = (c >= 3) ? pv[c-3] : 1'b0;
      n_tests++;
      if (out_valid !== exp_v) begin
        n_fail++; $display("FAIL bubble_c%0d: out_valid=%b, required %b", c, out_valid, exp_v);
      end else if (exp_v && y !== 32'h40000000) begin
        n_fail++; $display("FAIL bubble_y_c%0d: y=%h, required 40000000", c, y);
      end
      in_valid = pv[c];
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midop;
    logic [31:0] ry, ryt;
    logic [2:0]  rf, rft;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h40000000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || y !== 32'h40000000) begin
      n_fail++; $display("FAIL midop_pre: out_valid=%b y=%h, required 1/40000000", out_valid, y);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || y !== 32'h0) begin
      n_fail++; $display("FAIL midop_async: out_valid=%b y=%h, required 0/00000000", out_valid, y);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midop_quiet_c%0d: out_valid=%b, required 0", c, out_valid);
      end
    end
    issue(32'h3F800000, 32'h40400000, ry, ryt, rf, rft, lat);
    n_tests++;
    if (ry !== 32'h40400000 || lat != 3) begin
      n_fail++; $display("FAIL midop_after: y=%h lat=%0d, required 40400000/3", ry, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_backpressure();
    test_bubbles();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
